// File: rtl/dm_pkg.sv
// ----------------------------------------------------------------------------
// dm_pkg
// Shared definitions for the data-memory responder:
//   - store size encodings (DM_SIZE_*)
//   - dm_entry_t : one pending store (word index, lane mask, lane-aligned data)
//   - dm_lane_t  : result of lane alignment (mask, aligned data, overflow)
//   - dm_align() : maps (size, byte offset, right-aligned data) onto the
//                  big-endian lanes of a 32-bit word
// ----------------------------------------------------------------------------
package dm_pkg;

    localparam logic [1:0] DM_SIZE_WORD   = 2'd0;
    localparam logic [1:0] DM_SIZE_BYTE   = 2'd1;
    localparam logic [1:0] DM_SIZE_HALF   = 2'd2;
    localparam logic [1:0] DM_SIZE_TRIPLE = 2'd3;

    // Word index field is wide enough for any array size; the top level
    // zero-extends its ADDR_WIDTH-bit index into it.
    localparam int DM_IDX_W = 30;

    typedef struct packed {
        logic [DM_IDX_W-1:0] idx;
        logic [3:0]          mask;   // bit k = lane k (address offset k)
        logic [31:0]         data;   // already placed in its lanes
    } dm_entry_t;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
        logic        overflow;       // some bytes fell past lane 3
    } dm_lane_t;

    // Lane k lives in bits [31-8k -: 8] (big-endian). For a partial store of
    // n bytes at offset a, the most significant of the n data bytes lands in
    // lane a and successive bytes fill the following lanes; lanes past 3 are
    // dropped and reported through overflow.
    function automatic dm_lane_t dm_align(input logic [1:0]  size,
                                          input logic [1:0]  offset,
                                          input logic [31:0] wdata);
        dm_lane_t r;
        int       n;
        int       j;
        r = '0;
        case (size)
            DM_SIZE_BYTE:   n = 1;
            DM_SIZE_HALF:   n = 2;
            DM_SIZE_TRIPLE: n = 3;
            default:        n = 4;
        endcase
        if (size == DM_SIZE_WORD) begin
            r.mask = 4'hF;
            r.data = wdata;
        end else begin
            for (int k = 0; k < 4; k++) begin
                j = k - int'(offset);
                if (j >= 0 && j < n) begin
                    r.mask[k]           = 1'b1;
                    r.data[31-8*k -: 8] = wdata[8*(n-1-j) +: 8];
                end
            end
            r.overflow = (int'(offset) + n) > 4;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// ----------------------------------------------------------------------------
// data_memory_responder_if
// MEM-stage <-> data-memory bus.
//   master (pipeline): drives address, write data/size, read/write strobes;
//                      receives read data, stall and address-error flag.
//   slave  (memory)  : the reverse.
// ----------------------------------------------------------------------------
interface data_memory_responder_if;

    logic [31:0] data_address_2DM;
    logic [31:0] data_write_2DM;
    logic [1:0]  data_write_size_2DM;
    logic        MemRead_2DM;
    logic        MemWrite_2DM;
    logic [31:0] data_read_fDM;
    logic        DM_Stall;
    logic        DM_AddrError;

    modport master (
        output data_address_2DM, data_write_2DM, data_write_size_2DM,
               MemRead_2DM, MemWrite_2DM,
        input  data_read_fDM, DM_Stall, DM_AddrError
    );

    modport slave (
        input  data_address_2DM, data_write_2DM, data_write_size_2DM,
               MemRead_2DM, MemWrite_2DM,
        output data_read_fDM, DM_Stall, DM_AddrError
    );

endinterface

// File: rtl/dm_store_buffer.sv
// ----------------------------------------------------------------------------
// dm_store_buffer
// In-order store FIFO with per-lane forwarding.
// Ports:
//   CLK, RESET     : clock, asynchronous active-high reset (control only)
//   i_push/i_entry : enqueue one store at the tail
//   i_pop          : retire the head entry
//   i_idx          : word index being read, for forwarding
//   o_head         : head entry (next to drain)
//   o_count        : number of pending entries
//   o_hit_mask     : lanes supplied by pending stores for i_idx
//   o_hit_data     : those lanes' data, youngest store winning
// ----------------------------------------------------------------------------
module dm_store_buffer
    import dm_pkg::*;
#(
    parameter int SB_DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         i_push,
    input  dm_entry_t                    i_entry,
    input  logic                         i_pop,
    input  logic [DM_IDX_W-1:0]          i_idx,
    output dm_entry_t                    o_head,
    output logic [$clog2(SB_DEPTH):0]    o_count,
    output logic [3:0]                   o_hit_mask,
    output logic [31:0]                  o_hit_data
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    dm_entry_t           r_ent [SB_DEPTH];
    logic [SB_DEPTH-1:0] r_vld;
    logic [PW-1:0]       r_head;
    logic [PW-1:0]       r_tail;
    logic [CW-1:0]       r_count;
    logic [PW-1:0]       w_slot;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
        end else begin
            if (i_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PW'(1);
            end
            if (i_push) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload carries no reset; r_vld alone decides liveness.
    always_ff @(posedge CLK) begin
        if (i_push) begin
            r_ent[r_tail] <= i_entry;
        end
    end

    // Walk oldest -> youngest so a younger matching lane overwrites an older one.
    always_comb begin
        o_hit_mask = '0;
        o_hit_data = '0;
        w_slot     = r_head;
        for (int i = 0; i < SB_DEPTH; i++) begin
            w_slot = r_head + PW'(i);
            if (r_vld[w_slot] && (r_ent[w_slot].idx == i_idx)) begin
                for (int k = 0; k < 4; k++) begin
                    if (r_ent[w_slot].mask[k]) begin
                        o_hit_mask[k]            = 1'b1;
                        o_hit_data[31-8*k -: 8]  = r_ent[w_slot].data[31-8*k -: 8];
                    end
                end
            end
        end
    end

    assign o_head  = r_ent[r_head];
    assign o_count = r_count;

endmodule

// File: rtl/data_memory_responder.sv
// ----------------------------------------------------------------------------
// data_memory_responder
// Responder end of the MEM-stage data-memory interface: a single-ported word
// array fronted by an in-order store buffer. Reads are combinational and
// merge pending stores byte-wise; the buffer drains one entry per cycle
// whenever no read occupies the port.
// Ports:
//   CLK   : clock
//   RESET : asynchronous active-high reset
//   bus   : data_memory_responder_if.slave
//           in : data_address_2DM, data_write_2DM, data_write_size_2DM,
//                MemRead_2DM, MemWrite_2DM
//           out: data_read_fDM (combinational), DM_Stall (buffer full),
//                DM_AddrError (sticky, store ran past lane 3)
// ----------------------------------------------------------------------------
module data_memory_responder
    import dm_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int SB_DEPTH   = 4
) (
    input logic                    CLK,
    input logic                    RESET,
    data_memory_responder_if.slave bus
);

    localparam int CW = $clog2(SB_DEPTH) + 1;

    logic [31:0]           r_mem [2**ADDR_WIDTH];
    logic                  r_addr_err;

    logic [ADDR_WIDTH-1:0] w_idx;
    logic [ADDR_WIDTH-1:0] w_head_idx;
    dm_lane_t              w_align;
    dm_entry_t             w_new;
    dm_entry_t             w_head;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_stall;
    logic [CW-1:0]         w_count;
    logic [3:0]            w_hit_mask;
    logic [31:0]           w_hit_data;
    logic [31:0]           w_word;
    logic [31:0]           w_read;
    logic [31:0]           w_commit;
    logic                  w_unused;

    // Upper address bits alias onto the array.
    assign w_idx   = bus.data_address_2DM[ADDR_WIDTH+1:2];
    assign w_align = dm_align(bus.data_write_size_2DM,
                              bus.data_address_2DM[1:0],
                              bus.data_write_2DM);
    assign w_new   = '{idx: DM_IDX_W'(w_idx), mask: w_align.mask, data: w_align.data};

    assign w_stall = (w_count == CW'(SB_DEPTH));
    assign w_push  = bus.MemWrite_2DM && !w_stall;
    // A read owns the single array port, so it blocks the drain.
    assign w_pop   = (w_count != '0) && !bus.MemRead_2DM;

    dm_store_buffer #(
        .SB_DEPTH (SB_DEPTH)
    ) u_sb (
        .CLK        (CLK),
        .RESET      (RESET),
        .i_push     (w_push),
        .i_entry    (w_new),
        .i_pop      (w_pop),
        .i_idx      (DM_IDX_W'(w_idx)),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_hit_mask (w_hit_mask),
        .o_hit_data (w_hit_data)
    );

    // Head entry merged over the current array word, written back as a whole.
    assign w_head_idx = w_head.idx[ADDR_WIDTH-1:0];

    always_comb begin
        w_commit = r_mem[w_head_idx];
        for (int k = 0; k < 4; k++) begin
            if (w_head.mask[k]) begin
                w_commit[31-8*k -: 8] = w_head.data[31-8*k -: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_pop) begin
            r_mem[w_head_idx] <= w_commit;
        end
    end

    always_comb begin
        w_word = r_mem[w_idx];
        w_read = w_word;
        for (int k = 0; k < 4; k++) begin
            if (w_hit_mask[k]) begin
                w_read[31-8*k -: 8] = w_hit_data[31-8*k -: 8];
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_addr_err <= 1'b0;
        end else if (w_push && w_align.overflow) begin
            r_addr_err <= 1'b1;
        end
    end

    assign bus.data_read_fDM = w_read;
    assign bus.DM_Stall      = w_stall;
    assign bus.DM_AddrError  = r_addr_err;

    assign w_unused = ^{bus.data_address_2DM[31:ADDR_WIDTH+2],
                        w_head.idx[DM_IDX_W-1:ADDR_WIDTH]};

endmodule

// File: tb/tb_data_memory_responder.sv
// ----------------------------------------------------------------------------
// tb_data_memory_responder
// Scoreboard bench: expected read data is queued when a read is set up and
// popped/compared while the combinational output is stable.
// ----------------------------------------------------------------------------
module tb_data_memory_responder;

    localparam int AW  = 10;
    localparam int SBD = 4;

    logic CLK = 1'b0;
    logic RESET;

    always #5 CLK = ~CLK;

    data_memory_responder_if bus();

    data_memory_responder #(
        .ADDR_WIDTH (AW),
        .SB_DEPTH   (SBD)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one edge; return at the following negedge.
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [1:0] size, input logic rd);
        bus.data_address_2DM    = addr;
        bus.data_write_2DM      = data;
        bus.data_write_size_2DM = size;
        bus.MemRead_2DM         = rd;
        bus.MemWrite_2DM        = 1'b1;
        tick();
        bus.MemWrite_2DM        = 1'b0;
    endtask

    // Enqueue a full word and let it drain on the next idle edge.
    task automatic preload(input logic [31:0] addr, input logic [31:0] data);
        wr(addr, data, 2'd0, 1'b0);
        tick();
    endtask

    task automatic expect_rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.data_address_2DM = addr;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        #1;
        check(tag_q.pop_front(), bus.data_read_fDM, exp_q.pop_front());
    endtask

    task automatic chk_cnt(input string tag, input int exp);
        check(tag, 32'(dut.w_count), 32'(exp));
    endtask

    initial begin
        RESET                   = 1'b1;
        bus.data_address_2DM    = '0;
        bus.data_write_2DM      = '0;
        bus.data_write_size_2DM = '0;
        bus.MemRead_2DM         = 1'b0;
        bus.MemWrite_2DM        = 1'b0;
        tick();
        tick();
        check("rst_stall", 32'(bus.DM_Stall), 32'd0);
        check("rst_err",   32'(bus.DM_AddrError), 32'd0);
        chk_cnt("rst_cnt", 0);
        RESET = 1'b0;
        tick();

        // 1: store then load next cycle, forwarded while the read blocks drain
        preload(32'h100, 32'h11223344);
        wr(32'h100, 32'hDEADBEEF, 2'd0, 1'b0);
        bus.MemRead_2DM = 1'b1;
        expect_rd("t1_fwd", 32'h100, 32'hDEADBEEF);
        tick();
        chk_cnt("t1_cnt_blocked", 1);
        bus.MemRead_2DM = 1'b0;
        tick();
        chk_cnt("t1_cnt_drained", 0);
        expect_rd("t1_array", 32'h100, 32'hDEADBEEF);

        // 2: byte and halfword merges
        preload(32'h100, 32'h11223344);
        wr(32'h101, 32'h000000AA, 2'd1, 1'b0);
        expect_rd("t2_sb", 32'h100, 32'h11AA3344);
        wr(32'h102, 32'h00005566, 2'd2, 1'b0);
        expect_rd("t2_sh", 32'h100, 32'h11AA5566);
        tick();
        expect_rd("t2_array", 32'h100, 32'h11AA5566);

        // 3: size-3 at offset 1, then a byte at offset 0
        preload(32'h104, 32'h00000000);
        wr(32'h105, 32'h00ABCDEF, 2'd3, 1'b0);
        expect_rd("t3_s3", 32'h104, 32'h00ABCDEF);
        wr(32'h104, 32'h00000077, 2'd1, 1'b0);
        expect_rd("t3_sb", 32'h104, 32'h77ABCDEF);
        check("t3_err", 32'(bus.DM_AddrError), 32'd0);

        // 4: fill the buffer behind a held read, then drain
        preload(32'h210, 32'hCAFE0000);
        for (int i = 0; i < 4; i++) begin
            wr(32'h200 + 32'(4*i), 32'hA0000000 + 32'(i), 2'd0, 1'b1);
            check($sformatf("t4_stall_%0d", i), 32'(bus.DM_Stall), (i == 3) ? 32'd1 : 32'd0);
        end
        wr(32'h210, 32'hBADBAD00, 2'd0, 1'b1);
        chk_cnt("t4_cnt_full", 4);
        check("t4_stall_hold", 32'(bus.DM_Stall), 32'd1);
        expect_rd("t4_not_enq", 32'h210, 32'hCAFE0000);
        bus.MemRead_2DM = 1'b0;
        tick();
        check("t4_stall_fall", 32'(bus.DM_Stall), 32'd0);
        chk_cnt("t4_cnt_3", 3);
        tick();
        tick();
        tick();
        chk_cnt("t4_cnt_0", 0);
        for (int i = 0; i < 4; i++) begin
            expect_rd($sformatf("t4_word_%0d", i), 32'h200 + 32'(4*i), 32'hA0000000 + 32'(i));
        end
        expect_rd("t4_w210", 32'h210, 32'hCAFE0000);

        // 5: two pending byte stores to the same lane, youngest wins
        preload(32'h100, 32'h00000000);
        wr(32'h103, 32'h00000001, 2'd1, 1'b1);
        wr(32'h103, 32'h00000002, 2'd1, 1'b1);
        chk_cnt("t5_cnt_2", 2);
        expect_rd("t5_young", 32'h100, 32'h00000002);
        bus.MemRead_2DM = 1'b0;
        tick();
        tick();
        chk_cnt("t5_cnt_0", 0);
        expect_rd("t5_array", 32'h100, 32'h00000002);

        // 6: store spilling past lane 3, sticky error, then reset mid-buffer
        preload(32'h108, 32'h01020304);
        check("t6_err_pre", 32'(bus.DM_AddrError), 32'd0);
        wr(32'h10B, 32'h0000BEEF, 2'd2, 1'b1);
        check("t6_err_set", 32'(bus.DM_AddrError), 32'd1);
        expect_rd("t6_lane3", 32'h108, 32'h010203BE);
        wr(32'h100, 32'h55555555, 2'd0, 1'b1);
        check("t6_err_sticky", 32'(bus.DM_AddrError), 32'd1);
        chk_cnt("t6_cnt_2", 2);
        RESET = 1'b1;
        #1;
        check("t6_rst_err",   32'(bus.DM_AddrError), 32'd0);
        check("t6_rst_stall", 32'(bus.DM_Stall), 32'd0);
        chk_cnt("t6_rst_cnt", 0);
        expect_rd("t6_rst_108", 32'h108, 32'h01020304);
        expect_rd("t6_rst_100", 32'h100, 32'h00000002);
        tick();
        RESET = 1'b0;
        bus.MemRead_2DM = 1'b0;
        tick();
        expect_rd("t6_after_100", 32'h100, 32'h00000002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
